// File: rtl/count_tick_ctrl.sv
// Run/step pushbutton front end: debounces two keys and produces the display counter's tick enable and run status.
// Build macro TICK_AUTO_REPEAT_EN adds auto-repeat ticks while the step key is held in STOPPED.
module count_tick_ctrl #(
  parameter int unsigned DIV_BASE        = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
`ifdef TICK_AUTO_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000
`endif
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       key_run_n,
  input  logic       key_step_n,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       running
);

  localparam int unsigned PW = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
`ifdef TICK_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_DELAY + 1);
`endif

  typedef enum logic {
    S_STOPPED = 1'b0,
    S_RUNNING = 1'b1
  } state_e;

  state_e             state_q;
  logic               running_q;
  logic               tick_q;
  logic [PW-1:0]      pre_q;
  logic [PW-1:0]      div_m1;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic               run_ev, step_ev;
`ifdef TICK_AUTO_REPEAT_EN
  logic               rep_armed_q;
  logic               rep_act_q;
  logic [RW-1:0]      rep_cnt_q;
`endif

  // Bit 0 carries the run key, bit 1 the step key.
  assign run_ev  = press_q[0];
  assign step_ev = press_q[1];

  assign div_m1 = PW'((DIV_BASE >> {rate_sel, 1'b0}) - 32'd1);

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (db_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end
    end
    press_d = stable_q & ~stable_d;
  end

  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '1;
      db_cnt_q  <= '0;
      press_q   <= '0;
      state_q   <= S_STOPPED;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      pre_q     <= '0;
`ifdef TICK_AUTO_REPEAT_EN
      rep_armed_q <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_cnt_q   <= '0;
`endif
    end else begin
      sync1_q  <= {key_step_n, key_run_n};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
      tick_q   <= 1'b0;
      case (state_q)
        S_STOPPED: begin
          if (run_ev) begin
            // A simultaneous step event is dropped here.
            state_q   <= S_RUNNING;
            running_q <= 1'b1;
            pre_q     <= '0;
`ifdef TICK_AUTO_REPEAT_EN
            rep_armed_q <= 1'b0;
            rep_act_q   <= 1'b0;
            rep_cnt_q   <= '0;
`endif
          end else if (step_ev) begin
            tick_q <= 1'b1;
            pre_q  <= '0;
`ifdef TICK_AUTO_REPEAT_EN
            rep_armed_q <= 1'b1;
            rep_act_q   <= 1'b0;
            rep_cnt_q   <= '0;
`endif
          end else begin
`ifdef TICK_AUTO_REPEAT_EN
            // Release (including the edge that accepts it) stops repeating without a trailing tick.
            if (stable_d[1] || !rep_armed_q) begin
              rep_armed_q <= 1'b0;
              rep_act_q   <= 1'b0;
              rep_cnt_q   <= '0;
              pre_q       <= '0;
            end else if (!rep_act_q) begin
              pre_q <= '0;
              if (rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
                tick_q    <= 1'b1;
                rep_act_q <= 1'b1;
              end else begin
                rep_cnt_q <= rep_cnt_q + RW'(1);
              end
            end else if (pre_q >= div_m1) begin
              tick_q <= 1'b1;
              pre_q  <= '0;
            end else begin
              pre_q <= pre_q + PW'(1);
            end
`else
            pre_q <= '0;
`endif
          end
        end
        S_RUNNING: begin
          if (run_ev) begin
            state_q   <= S_STOPPED;
            running_q <= 1'b0;
            pre_q     <= '0;
          end else if (pre_q >= div_m1) begin
            // >= so a rate change below the current count ticks at once.
            tick_q <= 1'b1;
            pre_q  <= '0;
          end else begin
            pre_q <= pre_q + PW'(1);
          end
        end
      endcase
    end
  end

  assign tick    = tick_q;
  assign running = running_q;

endmodule
